// File: rtl/sprite_pkg.sv
// Shared types and default animation tables for the per-player sprite mapper.
// Tables pack 16 entries of 6 bits each, entry n living at bits [n*6 +: 6].
package sprite_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_MOVE = 4'd1,
        S_JUMP = 4'd2,
        S_ATK1 = 4'd3,
        S_ATK2 = 4'd4,
        S_HIT  = 4'd5
    } anim_state_e;

    localparam int DEF_SPR_W = 126;
    localparam int DEF_SPR_H = 126;

    // idle 0/10, move 10/8, atk1 18/18; every other state is unmapped
    localparam logic [95:0] DEF_STATE_BASE = (96'd18 << 18) | (96'd10 << 6);
    localparam logic [95:0] DEF_STATE_LEN  = (96'd18 << 18) | (96'd8 << 6) | 96'd10;

    function automatic logic [5:0] tbl_entry(input logic [95:0] tbl, input logic [3:0] idx);
        return tbl[idx*6 +: 6];
    endfunction

endpackage

// File: rtl/sprite_pipe_mapper_if.sv
// Sheet-ROM read port; the mapper is the master, the shared ROM the slave.
interface sprite_pipe_mapper_if #(
    parameter int ROM_AW = 20
);
    logic [ROM_AW-1:0] rom_addr;
    logic [11:0]       rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_flash_ctl.sv
// Hit-flash counter plus a per-video-frame shadow of the flash colour, so the
// flash state only ever changes between frames.
module sprite_flash_ctl #(
    parameter int FLASH_FRAMES = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic hit_pulse,
    output logic flash_white
);
    localparam int CW = $clog2(FLASH_FRAMES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          flash_q, flash_d;

    // The shadow samples the post-update count, so the frame that follows a
    // frame_start shows the parity of the count it runs under.
    always_comb begin
        cnt_d   = cnt_q;
        flash_d = flash_q;
        if (hit_pulse) begin
            cnt_d = CW'(FLASH_FRAMES);
        end else if (frame_start && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (frame_start) begin
            flash_d = (cnt_d != '0) && cnt_d[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            flash_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            flash_q <= flash_d;
        end
    end

    assign flash_white = flash_q;

endmodule

// File: rtl/sprite_pipe_mapper.sv
// Pipelined per-player sprite mapper: scan position -> sheet-ROM address ->
// keyed, optionally flashed pixel, with a fixed latency of ROM_LAT+3 cycles.
module sprite_pipe_mapper
    import sprite_pkg::*;
#(
    parameter int          SPR_W        = DEF_SPR_W,
    parameter int          SPR_H        = DEF_SPR_H,
    parameter int          NUM_FRAMES   = 36,
    parameter int          ROM_AW       = 20,
    parameter int          ROM_LAT      = 1,
    parameter logic [11:0] KEY_RGB      = 12'h000,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [95:0] STATE_BASE   = DEF_STATE_BASE,
    parameter logic [95:0] STATE_LEN    = DEF_STATE_LEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [9:0]           hcount,
    input  logic [9:0]           vcount,
    input  logic                 frame_start,
    input  logic [9:0]           pos_x,
    input  logic [9:0]           pos_y,
    input  logic                 facing_right,
    input  logic [3:0]           anim_state,
    input  logic [5:0]           anim_frame,
    input  logic                 hit_pulse,
    sprite_pipe_mapper_if.master rom,
    output logic                 sprite_on,
    output logic [11:0]          sprite_rgb
);
    localparam logic [ROM_AW-1:0] FRAME_SZ = ROM_AW'(SPR_W * SPR_H);

    logic [5:0] st_len, st_base;
    logic [6:0] frame_res;

    logic [9:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic       facing_q, facing_d;
    logic [6:0] frame_q, frame_d;

    logic       s0_inside_q, s0_inside_d;
    logic [6:0] s0_row_q, s0_row_d, s0_col_q, s0_col_d;
    logic [6:0] s0_frame_q, s0_frame_d;
    logic [6:0] col_raw;

    logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
    logic               s1_inside_q, s1_inside_d;
    logic [ROM_LAT-1:0] lat_q, lat_d;

    logic        on_q, on_d;
    logic [11:0] rgb_q, rgb_d;
    logic        flash_white;

    sprite_flash_ctl #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .hit_pulse   (hit_pulse),
        .flash_white (flash_white)
    );

    // Unmapped states fall back to state 0's first frame; overruns clamp to base.
    always_comb begin
        st_len  = tbl_entry(STATE_LEN, anim_state);
        st_base = tbl_entry(STATE_BASE, anim_state);
        if (st_len == '0) begin
            frame_res = {1'b0, tbl_entry(STATE_BASE, 4'd0)};
        end else if (anim_frame >= st_len) begin
            frame_res = {1'b0, st_base};
        end else begin
            frame_res = {1'b0, st_base} + {1'b0, anim_frame};
        end
        if (frame_res >= 7'(NUM_FRAMES)) begin
            frame_res = '0;
        end
    end

    always_comb begin
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        facing_d = facing_q;
        frame_d  = frame_q;
        if (frame_start) begin
            pos_x_d  = pos_x;
            pos_y_d  = pos_y;
            facing_d = facing_right;
            frame_d  = frame_res;
        end
    end

    // Only the low 7 bits of row/col matter once the pixel is known to be inside.
    always_comb begin
        s0_inside_d = ({1'b0, hcount} >= {1'b0, pos_x_q}) &&
                      ({1'b0, hcount} <  ({1'b0, pos_x_q} + 11'(SPR_W))) &&
                      ({1'b0, vcount} >= {1'b0, pos_y_q}) &&
                      ({1'b0, vcount} <  ({1'b0, pos_y_q} + 11'(SPR_H)));
        s0_row_d    = vcount[6:0] - pos_y_q[6:0];
        col_raw     = hcount[6:0] - pos_x_q[6:0];
        s0_col_d    = facing_q ? col_raw : 7'(SPR_W - 1) - col_raw;
        s0_frame_d  = frame_q;
    end

    always_comb begin
        s1_inside_d = s0_inside_q;
        rom_addr_d  = rom_addr_q;
        if (s0_inside_q) begin
            rom_addr_d = ROM_AW'(s0_frame_q) * FRAME_SZ +
                         ROM_AW'(s0_row_q) * ROM_AW'(SPR_W) +
                         ROM_AW'(s0_col_q);
        end
        lat_d[0] = s1_inside_q;
        for (int i = 1; i < ROM_LAT; i++) begin
            lat_d[i] = lat_q[i-1];
        end
    end

    always_comb begin
        on_d  = lat_q[ROM_LAT-1] && (rom.rom_data != KEY_RGB);
        rgb_d = 12'h000;
        if (on_d) begin
            rgb_d = flash_white ? 12'hFFF : rom.rom_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_q     <= '0;
            pos_y_q     <= '0;
            facing_q    <= 1'b0;
            frame_q     <= '0;
            s0_inside_q <= 1'b0;
            s0_row_q    <= '0;
            s0_col_q    <= '0;
            s0_frame_q  <= '0;
            s1_inside_q <= 1'b0;
            rom_addr_q  <= '0;
            lat_q       <= '0;
            on_q        <= 1'b0;
            rgb_q       <= '0;
        end else begin
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            facing_q    <= facing_d;
            frame_q     <= frame_d;
            s0_inside_q <= s0_inside_d;
            s0_row_q    <= s0_row_d;
            s0_col_q    <= s0_col_d;
            s0_frame_q  <= s0_frame_d;
            s1_inside_q <= s1_inside_d;
            rom_addr_q  <= rom_addr_d;
            lat_q       <= lat_d;
            on_q        <= on_d;
            rgb_q       <= rgb_d;
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign sprite_on    = on_q;
    assign sprite_rgb   = rgb_q;

endmodule

// File: tb/tb_sprite_pipe_mapper.sv
// Randomised bench for sprite_pipe_mapper against a frame-level reference model
// built from the sprite geometry, animation tables and flash rules.
module tb_sprite_pipe_mapper;
    import sprite_pkg::*;

    localparam int SPR_W        = 126;
    localparam int SPR_H        = 126;
    localparam int NUM_FRAMES   = 36;
    localparam int ROM_AW       = 20;
    localparam int FLASH_FRAMES = 8;
    localparam logic [9:0] OUTP = 10'd1023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  hcount = OUTP, vcount = OUTP, pos_x = '0, pos_y = '0;
    logic        frame_start = 1'b0, facing_right = 1'b0, hit_pulse = 1'b0;
    logic [3:0]  anim_state = '0;
    logic [5:0]  anim_frame = '0;
    logic        sprite_on;
    logic [11:0] sprite_rgb;

    sprite_pipe_mapper_if #(.ROM_AW(ROM_AW)) rom_bus ();

    sprite_pipe_mapper #(.ROM_LAT(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hcount       (hcount),
        .vcount       (vcount),
        .frame_start  (frame_start),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .facing_right (facing_right),
        .anim_state   (anim_state),
        .anim_frame   (anim_frame),
        .hit_pulse    (hit_pulse),
        .rom          (rom_bus.master),
        .sprite_on    (sprite_on),
        .sprite_rgb   (sprite_rgb)
    );

    always #5 clk = ~clk;

    // Synthetic sheet: every fifth address is the transparent key colour.
    function automatic logic [11:0] romPix(input int unsigned a);
        logic [31:0] h;
        if (a % 5 == 0) return 12'h000;
        h = a * 32'd2654435761;
        return h[18:7] | 12'h001;
    endfunction

    always @(posedge clk) rom_bus.rom_data <= romPix(32'(rom_bus.rom_addr));

    int baseTbl[16] = '{0, 10, 0, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int lenTbl[16]  = '{10, 8, 0, 18, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    int shX, shY, shFrame, flashCnt, lastAddr;
    bit shFacing, shWhite;
    int addrQ[$];
    logic [12:0] pixQ[$];
    int passCount = 0, checkCount = 0;

    logic [9:0] curPx = '0, curPy = '0;
    bit         curFr = 1'b0;
    logic [3:0] curSt = '0;
    logic [5:0] curFm = '0;

    function automatic int resolveFrame(input int st, input int fm);
        int r;
        if (lenTbl[st] == 0) r = baseTbl[0];
        else if (fm >= lenTbl[st]) r = baseTbl[st];
        else r = baseTbl[st] + fm;
        if (r >= NUM_FRAMES) r = 0;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, actual, expected, $time);
    endtask

    task automatic modelReset();
        shX = 0; shY = 0; shFrame = 0; shFacing = 1'b0; shWhite = 1'b0;
        flashCnt = 0; lastAddr = 0;
        addrQ.delete(); pixQ.delete();
        repeat (2) addrQ.push_back(0);
        repeat (4) pixQ.push_back(13'h0);
    endtask

    // One pixel clock: check what the pipeline should be showing now, then drive.
    task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v, input bit fs, input bit hit);
        int hi, vi, row, col, ea;
        bit ins;
        logic [12:0] ep;
        @(posedge clk); #1;
        if (addrQ.size() == 2) begin
            ea = addrQ.pop_front();
            checkOutput("rom_addr", 32'(rom_bus.rom_addr), 32'(ea));
        end
        if (pixQ.size() == 4) begin
            ep = pixQ.pop_front();
            checkOutput("sprite_on", 32'(sprite_on), 32'(ep[12]));
            checkOutput("sprite_rgb", 32'(sprite_rgb), 32'(ep[11:0]));
        end
        hcount = h; vcount = v; frame_start = fs; hit_pulse = hit;
        pos_x = curPx; pos_y = curPy; facing_right = curFr;
        anim_state = curSt; anim_frame = curFm;

        hi = int'(h); vi = int'(v);
        ins = hi >= shX && hi < shX + SPR_W && vi >= shY && vi < shY + SPR_H;
        if (ins) begin
            row = vi - shY;
            col = hi - shX;
            if (!shFacing) col = SPR_W - 1 - col;
            lastAddr = shFrame * SPR_W * SPR_H + row * SPR_W + col;
        end
        addrQ.push_back(lastAddr);
        if (ins && romPix(lastAddr) != 12'h000) ep = {1'b1, shWhite ? 12'hFFF : romPix(lastAddr)};
        else ep = 13'h0;
        pixQ.push_back(ep);

        if (hit) flashCnt = FLASH_FRAMES;
        else if (fs && flashCnt > 0) flashCnt--;
        if (fs) begin
            shX = int'(curPx); shY = int'(curPy); shFacing = curFr;
            shFrame = resolveFrame(int'(curSt), int'(curFm));
            shWhite = (flashCnt % 2) == 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(OUTP, OUTP, 1'b0, 1'b0);
    endtask

    task automatic newFrame(input logic [9:0] px, input logic [9:0] py, input bit fr,
                            input logic [3:0] st, input logic [5:0] fm, input bit hit);
        idle(4);
        curPx = px; curPy = py; curFr = fr; curSt = st; curFm = fm;
        applyStimulus(OUTP, OUTP, 1'b1, hit);
    endtask

    task automatic scanThenHold(input logic [9:0] h, input logic [9:0] v, input int n);
        applyStimulus(h, v, 1'b0, 1'b0);
        idle(n);
    endtask

    initial begin
        logic [9:0] px, py;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rom_addr", 32'(rom_bus.rom_addr), 32'd0);
        checkOutput("reset_sprite_on", 32'(sprite_on), 32'd0);
        checkOutput("reset_sprite_rgb", 32'(sprite_rgb), 32'd0);
        #2 rst_n = 1'b1;

        newFrame(10'd100, 10'd200, 1'b0, S_IDLE, 6'd0, 1'b0);
        scanThenHold(10'd100, 10'd200, 2);
        checkOutput("mirror_corner", 32'(rom_bus.rom_addr), 32'd125);
        scanThenHold(10'd225, 10'd201, 2);
        checkOutput("mirror_row1", 32'(rom_bus.rom_addr), 32'd126);
        scanThenHold(10'd226, 10'd200, 4);
        checkOutput("right_edge_off", 32'(sprite_on), 32'd0);
        checkOutput("right_edge_hold", 32'(rom_bus.rom_addr), 32'd126);

        newFrame(10'd100, 10'd200, 1'b1, S_IDLE, 6'd0, 1'b0);
        scanThenHold(10'd100, 10'd200, 2);
        checkOutput("origin_addr", 32'(rom_bus.rom_addr), 32'd0);
        idle(2);
        checkOutput("key_pixel_on", 32'(sprite_on), 32'd0);
        checkOutput("key_pixel_rgb", 32'(sprite_rgb), 32'd0);
        scanThenHold(10'd101, 10'd200, 4);
        checkOutput("opaque_on", 32'(sprite_on), 32'd1);
        checkOutput("opaque_rgb", 32'(sprite_rgb), 32'(romPix(1)));

        newFrame(10'd100, 10'd200, 1'b1, S_MOVE, 6'd3, 1'b0);
        scanThenHold(10'd100, 10'd200, 2);
        checkOutput("move_f3_addr", 32'(rom_bus.rom_addr), 32'd206388);
        newFrame(10'd100, 10'd200, 1'b1, S_MOVE, 6'd9, 1'b0);
        scanThenHold(10'd100, 10'd200, 2);
        checkOutput("move_clamp_addr", 32'(rom_bus.rom_addr), 32'd158760);

        newFrame(10'd300, 10'd100, 1'b1, S_IDLE, 6'd2, 1'b0);
        scanThenHold(10'd305, 10'd110, 2);
        checkOutput("shadow_before", 32'(rom_bus.rom_addr), 32'd33017);
        curPx = 10'd50; curPy = 10'd60; curFr = 1'b0;
        scanThenHold(10'd305, 10'd110, 2);
        checkOutput("shadow_after", 32'(rom_bus.rom_addr), 32'd33017);

        // Flash: hit mid-frame, then frames at counts 7 (white), 6 (normal), ...
        applyStimulus(OUTP, OUTP, 1'b0, 1'b1);
        newFrame(10'd100, 10'd200, 1'b1, S_IDLE, 6'd0, 1'b0);
        scanThenHold(10'd101, 10'd200, 4);
        checkOutput("flash_cnt7", 32'(sprite_rgb), 32'hFFF);
        newFrame(10'd100, 10'd200, 1'b1, S_IDLE, 6'd0, 1'b0);
        scanThenHold(10'd101, 10'd200, 4);
        checkOutput("flash_cnt6", 32'(sprite_rgb), 32'(romPix(1)));
        for (int f = 0; f < 7; f++) begin
            newFrame(10'd100, 10'd200, 1'b1, S_IDLE, 6'd0, 1'b0);
            for (int p = 1; p < 4; p++) applyStimulus(10'(100 + p), 10'd200, 1'b0, 1'b0);
        end
        idle(4);
        checkOutput("flash_done", 32'(sprite_rgb), 32'(romPix(3)));
        newFrame(10'd100, 10'd200, 1'b1, S_IDLE, 6'd0, 1'b1);
        scanThenHold(10'd101, 10'd200, 4);
        checkOutput("flash_coincident8", 32'(sprite_rgb), 32'(romPix(1)));
        newFrame(10'd100, 10'd200, 1'b1, S_IDLE, 6'd0, 1'b0);
        scanThenHold(10'd101, 10'd200, 4);
        checkOutput("flash_coincident7", 32'(sprite_rgb), 32'hFFF);

        for (int f = 0; f < 20; f++) begin
            px = 10'($urandom_range(0, 800));
            py = 10'($urandom_range(0, 800));
            newFrame(px, py, 1'($urandom), 4'($urandom), 6'($urandom), $urandom_range(0, 5) == 0);
            for (int s = 0; s < 150; s++) begin
                if ($urandom_range(0, 9) == 0) begin
                    curPx = 10'($urandom); curPy = 10'($urandom);
                    curFr = 1'($urandom); curSt = 4'($urandom); curFm = 6'($urandom);
                end
                applyStimulus(10'(int'(px) + $urandom_range(0, 139) - 7),
                              10'(int'(py) + $urandom_range(0, 139) - 7),
                              1'b0, $urandom_range(0, 60) == 0);
            end
        end

        newFrame(10'd100, 10'd200, 1'b1, S_IDLE, 6'd0, 1'b0);
        for (int p = 1; p < 5; p++) applyStimulus(10'(100 + p), 10'd200, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_on", 32'(sprite_on), 32'd0);
        checkOutput("async_rst_rgb", 32'(sprite_rgb), 32'd0);
        checkOutput("async_rst_addr", 32'(rom_bus.rom_addr), 32'd0);
        hcount = OUTP; vcount = OUTP; frame_start = 1'b0; hit_pulse = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        modelReset();
        for (int s = 0; s < 200; s++)
            applyStimulus(10'($urandom_range(0, 140)), 10'($urandom_range(0, 140)), 1'b0, 1'b0);
        idle(4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/sprite_pipe_mapper.md
# sprite_pipe_mapper

Parametrised, pipelined successor to the per-player sprite mapper: maps the VGA scan position to one pixel of a player's current animation frame, read from a single external sprite-sheet ROM. Player state is shadow-latched once per video frame (no mid-frame tearing). Adds hit-flash and a fixed, advertised pixel latency. Sits between the player state/animation logic and the compositor; one instance per player.

## Interface
Parameters:
- `SPR_W`, 126: sprite width in pixels (≤127)
- `SPR_H`, 126: sprite height in pixels (≤127)
- `NUM_FRAMES`, 36: total frames stored in the sheet ROM
- `ROM_AW`, 20: ROM address width; must cover `NUM_FRAMES*SPR_W*SPR_H`
- `ROM_LAT`, 1: ROM read latency in cycles (1 or 2)
- `KEY_RGB`, 12'h000: transparent colour key
- `FLASH_FRAMES`, 8: video frames a hit flash lasts
- `STATE_BASE`, 16×6 bits packed: first sheet frame for each `anim_state`
- `STATE_LEN`, 16×6 bits packed: frame count per state; 0 = unmapped

Ports:
- `clk` in 1: pixel clock
- `rst_n` in 1: reset, asynchronous, active-low
- `hcount`, `vcount` in 10 each: scan position
- `frame_start` in 1: one-cycle pulse at the start of vertical blank
- `pos_x`, `pos_y` in 10 each: sprite top-left corner
- `facing_right` in 1: 1 = unflipped, 0 = horizontally mirrored
- `anim_state` in 4, `anim_frame` in 6: animation selector
- `hit_pulse` in 1: one-cycle pulse that starts a hit flash
- `rom_addr` out `ROM_AW`: sheet ROM address
- `rom_data` in 12: ROM pixel, `ROM_LAT` cycles after `rom_addr`
- `sprite_on` out 1: opaque sprite pixel present
- `sprite_rgb` out 12: pixel colour; 12'h000 when `sprite_on`=0

## Operation
- Shadow registers: on `frame_start`, capture `pos_x`, `pos_y`, `facing_right`, and the resolved frame index. All pixel math uses the shadow copies only.
- Frame resolve:
  - `len = STATE_LEN[anim_state]`.
  - If `len==0`, use state 0's base with frame 0.
  - Else if `anim_frame >= len`, use `base + 0` (clamp to the state's first frame).
  - Else use `base + anim_frame`.
  - A result ≥`NUM_FRAMES` is forced to 0.
- Stage 0 (registered):
  - `inside` is computed with 11-bit compares (`pos+SPR_W` must not wrap).
  - `row = vcount-pos_y`; `col = hcount-pos_x`.
  - Mirror: `col' = SPR_W-1-col` when facing left.
- Stage 1 (registered): `rom_addr = frame*SPR_W*SPR_H + row*SPR_W + col'` (constant multiplies only).
- `inside` is delayed alongside the address through `ROM_LAT`.
- Output stage (registered):
  - `sprite_on = inside_d && rom_data != KEY_RGB`.
  - `sprite_rgb = flash_white ? 12'hFFF : rom_data` when on, else 0.
- Flash counter (`$clog2(FLASH_FRAMES+1)` bits):
  - `hit_pulse` loads `FLASH_FRAMES`; a retrigger during a flash reloads.
  - `frame_start` decrements a nonzero counter.
  - If `hit_pulse` and `frame_start` arrive in the same cycle, load wins.
  - `flash_white = (cnt!=0) && cnt[0]`, sampled into a shadow at `frame_start` so a frame is never half-flashed.
- Outside the box, `rom_addr` holds its last value (no ROM toggle requirement; just stable).

## Timing
- Pixel latency: `LAT = ROM_LAT + 3` cycles from `hcount`/`vcount` to `sprite_on`/`sprite_rgb`. The compositor delays its scan position by `LAT`.
- Shadow updates take effect on the cycle after `frame_start`.
- Reset (async assert, sync release): `rom_addr`=0, `sprite_on`=0, `sprite_rgb`=0, shadows 0, flash counter 0, pipeline valid bits 0.
- Reset mid-line: outputs go to 0 immediately; the first valid pixel appears `LAT` cycles after release, using shadow = 0 until the next `frame_start`.

## Structure
- Shared package `sprite_pkg` holds:
  - state encodings (`S_IDLE`=0, `S_MOVE`=1, `S_JUMP`=2, `S_ATK1`=3, `S_ATK2`=4, `S_HIT`=5);
  - default `STATE_BASE`/`STATE_LEN` vectors (idle 0/10, move 10/8, atk1 18/18);
  - `SPR_W`/`SPR_H` defaults.
- One natural sub-module: `sprite_flash_ctl` (flash counter plus flash shadow).
- The sheet ROM stays outside the block so both players can share a dual-port ROM.

## Test plan
- Reset, then `frame_start` with pos=(100,200), state 0, frame 0, scan (100,200): `rom_addr`=0; `sprite_on` follows ROM data at `LAT`=4 (`ROM_LAT`=1).
- Facing left at scan (100,200), frame 0: `rom_addr`=125. Scan (225,201): `rom_addr`=126. Scan (226,200): `sprite_on`=0.
- State 1, frame 3, corner pixel: `rom_addr = 13*15876 = 206388`. `anim_frame`=9 in state 1: clamps to frame 10, address 158760.
- `pos_x` changed mid-frame with no `frame_start`: output unchanged until the next `frame_start`.
- `hit_pulse`, then 8 `frame_start`s with opaque ROM data: white on frames with odd counter (8→7 white, 6 normal, …); normal after the counter reaches 0. `hit_pulse` coincident with `frame_start`: counter = 8.
- Pixel with `rom_data`=12'h000 inside the box: `sprite_on`=0, `sprite_rgb`=0. Async reset asserted mid-pixel: outputs 0 in the same cycle.
